// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks the register mask R0..R7, one transfer per unstalled cycle; done at T+k+1, `stall` holds the current transfer.
// `define LMSM_BASE_UPDATE_EN to add a WB cycle writing Ra <- base + transfer count (done at T+k+2).
module lmsm_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_load,
   input  logic [7:0]  mask,
   input  logic [15:0] base,
   input  logic [2:0]  ra,
   input  logic        stall,
   input  logic [15:0] mem_rdata,
   output logic [2:0]  reg_add,
   output logic        reg_write_n,
   output logic [15:0] reg_wdata,
   output logic [15:0] mem_add,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic        r7_loaded
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_WB, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [7:0]  rem_q, rem_d;
   logic [3:0]  offset_q, offset_d;
   logic [15:0] base_q, base_d;
   logic        is_load_q, is_load_d;
   logic [2:0]  ra_q, ra_d;
   logic        r7_sel_q, r7_sel_d;

   logic [2:0]  low_idx;
   logic [7:0]  rem_clr;
   logic [15:0] cur_addr;

   // Highest index is visited first, so the last hit is the lowest set bit.
   always_comb begin
      low_idx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (rem_q[i]) low_idx = 3'(i);
      end
   end

   assign rem_clr  = rem_q & ~(8'b1 << low_idx);
   assign cur_addr = base_q + 16'(offset_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         rem_q     <= 8'd0;
         offset_q  <= 4'd0;
         base_q    <= 16'd0;
         is_load_q <= 1'b0;
         ra_q      <= 3'd0;
         r7_sel_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rem_q     <= rem_d;
         offset_q  <= offset_d;
         base_q    <= base_d;
         is_load_q <= is_load_d;
         ra_q      <= ra_d;
         r7_sel_q  <= r7_sel_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      offset_d  = offset_q;
      base_d    = base_q;
      is_load_d = is_load_q;
      ra_d      = ra_q;
      r7_sel_d  = r7_sel_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               rem_d     = mask;
               offset_d  = 4'd0;
               base_d    = base;
               is_load_d = is_load;
               ra_d      = ra;
               r7_sel_d  = mask[7];
               state_d   = (mask != 8'd0) ? S_XFER : S_DONE;
            end
         end
         S_XFER: begin
            if (!stall) begin
               rem_d    = rem_clr;
               offset_d = offset_q + 4'd1;
               if (rem_clr == 8'd0) begin
`ifdef LMSM_BASE_UPDATE_EN
                  state_d = S_WB;
`else
                  state_d = S_DONE;
`endif
               end
            end
         end
         S_WB:    state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      reg_add     = 3'd0;
      reg_write_n = 1'b1;
      reg_wdata   = 16'd0;
      mem_add     = 16'd0;
      mem_we      = 1'b0;
      busy        = (state_q != S_IDLE);
      done        = 1'b0;
      r7_loaded   = 1'b0;
      case (state_q)
         S_XFER: begin
            reg_add = low_idx;
            mem_add = cur_addr;
            if (!stall) begin
               if (is_load_q) begin
                  reg_write_n = 1'b0;
                  reg_wdata   = mem_rdata;
               end else begin
                  mem_we = 1'b1;
               end
            end
         end
         S_WB: begin
            reg_add     = ra_q;
            reg_wdata   = cur_addr;
            reg_write_n = 1'b0;
         end
         S_DONE: begin
            done      = 1'b1;
            r7_loaded = is_load_q & r7_sel_q;
         end
         default: ;
      endcase
   end

endmodule
